// File: rtl/vga_scanout_if.sv
// Pixel FIFO read conduit between the display FIFO (slave) and vga_scanout (master).
interface vga_scanout_if;
  logic [23:0] fifo_rddata;
  logic        fifo_rdempty;
  logic        fifo_rdreq;

  modport master (input fifo_rddata, input fifo_rdempty, output fifo_rdreq);
  modport slave  (output fifo_rddata, output fifo_rdempty, input fifo_rdreq);
endinterface

// File: rtl/vga_scanout.sv
// VGA timing generator and pixel FIFO consumer; all video outputs are one register stage after the counters.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds the test_mode input).
module vga_scanout #(
  parameter int          H_ACTIVE        = 640,
  parameter int          H_FP            = 16,
  parameter int          H_SYNC          = 96,
  parameter int          H_BP            = 48,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_FP            = 10,
  parameter int          V_SYNC          = 2,
  parameter int          V_BP            = 33,
  parameter bit          HS_POL          = 1'b0,
  parameter bit          VS_POL          = 1'b0,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  vga_scanout_if.master fifo,
`ifdef VGA_TEST_PATTERN_EN
  input  logic          test_mode,
`endif
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic          vga_sync_n,
  output logic          frame_start,
  output logic [15:0]   underflow_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic [0:0]    state_r;
  logic [23:0]   rgb_r;
  logic          blank_n_r;
  logic          hs_r;
  logic          vs_r;
  logic          frame_start_r;
  logic [15:0]   underflow_count_r;

  logic          active_s;
  logic          hs_act_s;
  logic          vs_act_s;
  logic          frame_end_s;
  logic          test_s;
  logic          scan_s;
  logic          pop_s;
  logic          under_s;
  logic          show_s;
  logic [23:0]   rgb_s;

`ifdef VGA_TEST_PATTERN_EN
  logic test_r;

  function automatic logic [23:0] bar_color(input logic [HW-1:0] h);
    logic [2:0] idx;
    idx = 3'(int'(h) / (H_ACTIVE / 8));
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction

  // test_mode is only honoured from one frame boundary to the next so a frame is never mixed
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      test_r <= 1'b0;
    end else if (frame_end_s) begin
      test_r <= test_mode;
    end else begin
      test_r <= test_r;
    end
  end

  assign test_s = test_r;
`else
  assign test_s = 1'b0;
`endif

  // Free-running raster counters, independent of the scanout state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= {VW{1'b0}};
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= (v_cnt_r == V_LAST) ? {VW{1'b0}} : v_cnt_r + {{(VW-1){1'b0}}, 1'b1};
    end else begin
      h_cnt_r <= h_cnt_r + {{(HW-1){1'b0}}, 1'b1};
    end
  end

  // Raster decode and next-pixel selection
  always_comb begin
    active_s    = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    hs_act_s    = (h_cnt_r >= H_SYNC_S) && (h_cnt_r <= H_SYNC_E);
    vs_act_s    = (v_cnt_r >= V_SYNC_S) && (v_cnt_r <= V_SYNC_E);
    frame_end_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    scan_s      = (state_r == ST_RUN) && active_s && !test_s;
    pop_s       = scan_s && !fifo.fifo_rdempty;
    under_s     = scan_s && fifo.fifo_rdempty;
    show_s      = active_s && ((state_r == ST_RUN) || test_s);
    rgb_s       = 24'h000000;
`ifdef VGA_TEST_PATTERN_EN
    if (test_s && active_s) begin
      rgb_s = bar_color(h_cnt_r);
    end else
`endif
    if (pop_s) begin
      rgb_s = fifo.fifo_rddata;
    end else if (under_s) begin
      rgb_s = UNDERFLOW_COLOR;
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Start scanning only at a frame boundary with data waiting; never leave RUN afterwards
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= (frame_end_s && !fifo.fifo_rdempty) ? ST_RUN : ST_IDLE;
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Single output stage keeps RGB, syncs, blank and frame_start mutually aligned
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rgb_r             <= 24'h000000;
      blank_n_r         <= 1'b0;
      hs_r              <= ~HS_POL;
      vs_r              <= ~VS_POL;
      frame_start_r     <= 1'b0;
      underflow_count_r <= 16'h0000;
    end else begin
      rgb_r         <= rgb_s;
      blank_n_r     <= show_s;
      hs_r          <= hs_act_s ? HS_POL : ~HS_POL;
      vs_r          <= vs_act_s ? VS_POL : ~VS_POL;
      frame_start_r <= (state_r == ST_RUN) && (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
      if (under_s && (underflow_count_r != 16'hFFFF)) begin
        underflow_count_r <= underflow_count_r + 16'h0001;
      end else begin
        underflow_count_r <= underflow_count_r;
      end
    end
  end

  assign fifo.fifo_rdreq = pop_s;
  assign vga_r           = rgb_r[23:16];
  assign vga_g           = rgb_r[15:8];
  assign vga_b           = rgb_r[7:0];
  assign vga_hs          = hs_r;
  assign vga_vs          = vs_r;
  assign vga_blank_n     = blank_n_r;
  assign vga_sync_n      = 1'b0;
  assign frame_start     = frame_start_r;
  assign underflow_count = underflow_count_r;

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Display-side consumer of the pixel FIFO that the VPU composer fills through its wrreq/wrfull/pixel_out conduit. Runs in the pixel clock domain on the FIFO read port. Generates VGA timing and pulls one 24-bit RGB pixel per active cycle. Drives RGB, sync and blank to the video DAC. Reports FIFO underflow to the system.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
UNDERFLOW_COLOR, 24'hFF00FF, RGB driven on an active pixel when the FIFO is empty

Ports:
clk_clk  in  1  pixel clock, 25.175/25 MHz for the defaults
reset_reset_n  in  1  asynchronous active-low reset
fifo_rddata  in  24  show-ahead FIFO head {R[23:16],G[15:8],B[7:0]}, valid while fifo_rdempty=0
fifo_rdempty  in  1  FIFO empty
fifo_rdreq  out  1  pop head; combinational
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_blank_n  out  1  high during active video
vga_sync_n  out  1  tied 0 (no sync-on-green)
frame_start  out  1  one-cycle pulse aligned with the first active pixel of a frame
underflow_count  out  16  saturating count of empty-FIFO active pixels since reset

Behaviour:
- Clock and reset: single clock clk_clk. Reset reset_reset_n is asynchronous and active-low.
- Reset values:
  - h_cnt=0, v_cnt=0, state=IDLE.
  - vga_r/g/b=0, vga_blank_n=0.
  - vga_hs=~HS_POL, vga_vs=~VS_POL.
  - frame_start=0, underflow_count=0, fifo_rdreq=0.
- Counters:
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL is defined the same way (525).
  - h_cnt increments every clock and wraps H_TOTAL-1 -> 0.
  - v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0.
  - Counters run in all states.
- Decode on counters:
  - active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], whole lines.
- State machine:
  - IDLE: no reads; outputs blanked; syncs still toggle per timing. Go to RUN at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 if fifo_rdempty=0; otherwise stay and retest at the next frame end.
  - RUN: normal scanout; stays in RUN until reset.
- Read rule: fifo_rdreq = (state==RUN) && active && !fifo_rdempty. Never asserted outside active video.
- Output pipeline, one register stage; all outputs come from the same stage, so they stay mutually aligned with 1-clock latency from the counters:
  - vga_hs <= hs_act ? HS_POL : ~HS_POL. vga_vs likewise with VS_POL.
  - vga_blank_n <= active && state==RUN.
  - RGB <= fifo_rddata when active&&RUN&&!empty; UNDERFLOW_COLOR when active&&RUN&&empty; 0 otherwise.
- Underflow:
  - Each active RUN cycle with fifo_rdempty=1 increments underflow_count by 1; saturates at 16'hFFFF.
  - No pop on that cycle. The stream slips; there is no resync, and software monitors the count.
- frame_start is registered high the cycle after the counters are at (0,0) in RUN, i.e. coincident on the output with pixel (0,0). It is not asserted in IDLE.
- Reset mid-frame: all state clears immediately, asynchronously. FIFO contents are untouched; the upstream composer is responsible for flushing.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined:
  - Adds input test_mode (1 bit).
  - While test_mode=1: fifo_rdreq=0; underflow is not counted.
  - Active pixels show 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black), indexed by h_cnt. vga_blank_n is driven as in RUN, regardless of state.
  - Changing test_mode takes effect only at the frame boundary (sampled at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
- Undefined: no test_mode port; no pattern logic.

Test Plan:
- Reset then release with the FIFO preloaded with 640*480 words -> IDLE until (799,524); first fifo_rdreq at (0,0); pixel 0 data on vga_rgb 1 clock later with frame_start=1 and vga_blank_n=1.
- Free-run timing check -> vga_hs low for exactly 96 clocks starting 656 clocks after line start; vga_vs low for 2 lines starting at line 490; 800 clocks per line; 525 lines per frame.
- Empty FIFO at reset for 3 frames, then fill -> no rdreq and vga_blank_n=0 during the empty frames; RUN entered at the first frame end with data.
- Hold fifo_rdempty=1 for 10 active clocks mid-line in RUN -> RGB=FF00FF for those 10 pixels, underflow_count=10, no rdreq on those cycles.
- Force underflow_count to 16'hFFFE, then 5 empty active cycles -> count holds at 16'hFFFF.
- VGA_TEST_PATTERN_EN: test_mode=1 asserted mid-frame -> scanout continues from the FIFO until the frame boundary. Next frame: pixels 0..79 = FFFFFF, 80..159 = FFFF00, and fifo_rdreq stays 0.
